// File: rtl/imem_responder_if.sv
// Request/response/loader bundle between the fetch side and imem_responder.
interface imem_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              flush_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [ADDR_W-1:0] resp_addr_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_perr_o;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;

  // Fetch unit / loader side.
  modport master (
    output req_valid_i, req_addr_i, flush_i, resp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    input  req_ready_o, resp_valid_o, resp_addr_o, resp_data_o, resp_perr_o
  );

  // Responder side.
  modport slave (
    input  req_valid_i, req_addr_i, flush_i, resp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    output req_ready_o, resp_valid_o, resp_addr_o, resp_data_o, resp_perr_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: credit-controlled fixed-latency read pipeline feeding an
// in-order response buffer. Flush drops everything in flight.
// Optional macro IMEM_PARITY_EN adds a per-word even-parity bit and reports read mismatches
// on resp_perr_o; without it resp_perr_o is constant 0.
module imem_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  imem_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} buf_state_e;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;

  logic              accept, push, pop;
  logic [CNT_W-1:0]  credit_q, credit_d;

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_perr_q;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];

  logic [ADDR_W-1:0]    buf_addr_q [BUF_DEPTH];
  logic [DATA_W-1:0]    buf_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_perr_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  buf_state_e           state_q, state_d;

  assign rd_idx = bus.req_addr_i[IDX_W-1:0];
  assign wr_idx = bus.wr_addr_i[IDX_W-1:0];

  // Upper address bits only alias onto the RAM, they never select anything.
  if (ADDR_W > IDX_W) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr_i[ADDR_W-1:IDX_W], bus.wr_addr_i[ADDR_W-1:IDX_W]};
  end

  // Loader write port; never gated by flush or backpressure.
  always_ff @(posedge clk) begin
    if (bus.wr_en_i) mem_q[wr_idx] <= bus.wr_data_i;
  end

  // Read data is sampled into stage 0 on the same edge as a write, so it sees the old word.
  assign rd_data = mem_q[rd_idx];

`ifdef IMEM_PARITY_EN
  logic [MEM_DEPTH-1:0] par_q;

  // Parity is taken from the loader data, not from what ends up stored.
  always_ff @(posedge clk) begin
    if (bus.wr_en_i) par_q[wr_idx] <= ^bus.wr_data_i;
  end

  assign rd_perr = (^rd_data) != par_q[rd_idx];
`else
  assign rd_perr = 1'b0;
`endif

  // One credit per buffer slot keeps the pipeline from ever needing to stall.
  assign bus.req_ready_o = (credit_q < CNT_W'(BUF_DEPTH)) && !bus.flush_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign push            = pipe_vld_q[RD_LAT-1];
  assign pop             = bus.resp_valid_o && bus.resp_ready_i;

  // Credit counter: accepts take a credit, pops return it.
  always_comb begin
    credit_d = credit_q;
    if (bus.flush_i) credit_d = '0;
    else             credit_d = credit_q + CNT_W'(accept) - CNT_W'(pop);
  end

  // Occupancy and buffer state.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (bus.flush_i) count_d = '0;
    else             count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (count_d == '0)                      state_d = StEmpty;
    else if (count_d == CNT_W'(BUF_DEPTH)) state_d = StFull;
    else                                    state_d = StPartial;
  end

  // Control state: credits, occupancy, pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
      count_q  <= '0;
      state_q  <= StEmpty;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      state_q  <= state_d;
      if (bus.flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Read pipeline: stage 0 captures the RAM word, later stages just shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_perr_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_addr_q[i] <= '0;
        pipe_data_q[i] <= '0;
      end
    end else if (bus.flush_i) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0]  <= accept;
      pipe_perr_q[0] <= rd_perr;
      pipe_addr_q[0] <= bus.req_addr_i;
      pipe_data_q[0] <= rd_data;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_perr_q[i] <= pipe_perr_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Response buffer storage; entries are only visible through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (push && !bus.flush_i) begin
      buf_addr_q[wr_ptr_q] <= pipe_addr_q[RD_LAT-1];
      buf_data_q[wr_ptr_q] <= pipe_data_q[RD_LAT-1];
      buf_perr_q[wr_ptr_q] <= pipe_perr_q[RD_LAT-1];
    end
  end

  // Head entry drives the response port; zero when nothing is buffered.
  always_comb begin
    bus.resp_valid_o = (state_q != StEmpty);
    bus.resp_addr_o  = '0;
    bus.resp_data_o  = '0;
    bus.resp_perr_o  = 1'b0;
    if (bus.resp_valid_o) begin
      bus.resp_addr_o = buf_addr_q[rd_ptr_q];
      bus.resp_data_o = buf_data_q[rd_ptr_q];
      bus.resp_perr_o = buf_perr_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic, all checked against a
// transaction-level model (RAM array + queue of expected responses with ready times).
module tb_imem_responder;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH),
    .RD_LAT   (RD_LAT),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              perr;
    int                ready_edge;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] mdl_mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] mdl_bad = '0;
  int                edge_cnt = 0;
  int                n_checks = 0;
  int                n_pass   = 0;

  logic              obs_ready, obs_valid;
  logic [ADDR_W-1:0] got_addr_q[$];
  logic [DATA_W-1:0] got_data_q[$];
  logic              got_perr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_got();
    got_addr_q.delete();
    got_data_q.delete();
    got_perr_q.delete();
  endtask

  // One clock cycle: drive, compare with the model, then advance the model across the edge.
  task automatic step(input logic rv, input logic [ADDR_W-1:0] ra, input logic rr,
                      input logic fl, input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd);
    logic mv, mr, acc, pp;
    int   ri;
    @(negedge clk);
    bus.req_valid_i  = rv;
    bus.req_addr_i   = ra;
    bus.resp_ready_i = rr;
    bus.flush_i      = fl;
    bus.wr_en_i      = we;
    bus.wr_addr_i    = wa;
    bus.wr_data_i    = wd;
    #1;
    mr  = (exp_q.size() < int'(BUF_DEPTH)) && !fl;
    mv  = (exp_q.size() > 0) && (exp_q[0].ready_edge <= edge_cnt);
    acc = rv && mr;
    pp  = mv && rr;
    obs_ready = bus.req_ready_o;
    obs_valid = bus.resp_valid_o;
    check("req_ready", {31'd0, bus.req_ready_o}, {31'd0, mr});
    check("resp_valid", {31'd0, bus.resp_valid_o}, {31'd0, mv});
    if (mv) begin
      check("resp_addr", {16'd0, bus.resp_addr_o}, {16'd0, exp_q[0].addr});
      check("resp_data", {16'd0, bus.resp_data_o}, {16'd0, exp_q[0].data});
      check("resp_perr", {31'd0, bus.resp_perr_o}, {31'd0, exp_q[0].perr});
    end
    if (bus.resp_valid_o && rr) begin
      got_addr_q.push_back(bus.resp_addr_o);
      got_data_q.push_back(bus.resp_data_o);
      got_perr_q.push_back(bus.resp_perr_o);
    end
    @(posedge clk);
    edge_cnt++;
    ri = int'(ra[IDX_W-1:0]);
    if (fl) exp_q.delete();
    else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{addr: ra, data: mdl_mem[ri], perr: mdl_bad[ri],
                                 ready_edge: edge_cnt + int'(RD_LAT)});
    end
    if (we) begin
      mdl_mem[int'(wa[IDX_W-1:0])] = wd;
      mdl_bad[int'(wa[IDX_W-1:0])] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.wr_en_i     = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    check("rst_resp_addr", {16'd0, bus.resp_addr_o}, 32'd0);
    check("rst_resp_data", {16'd0, bus.resp_data_o}, 32'd0);
    check("rst_resp_perr", {31'd0, bus.resp_perr_o}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int acc_cnt;

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.resp_ready_i = 1'b0;
    bus.flush_i      = 1'b0;
    bus.wr_en_i      = 1'b0;
    bus.wr_addr_i    = '0;
    bus.wr_data_i    = '0;
    do_reset();

    // Give every RAM word a known value so random reads are fully predictable.
    for (int i = 0; i < int'(MEM_DEPTH); i++) wr(ADDR_W'(i), DATA_W'($urandom));
    for (int i = 0; i < 8; i++) wr(ADDR_W'(i), DATA_W'(16'hA0 + i));

    // Basic latency: visible in the cycle after edge N+2.
    wr(16'd5, 16'h1234);
    clear_got();
    step(1'b1, 16'd5, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(1);
    check("t1_lat_n1", {31'd0, obs_valid}, 32'd0);
    idle(1);
    check("t1_lat_n2", {31'd0, obs_valid}, 32'd0);
    idle(1);
    check("t1_lat_ok", {31'd0, obs_valid}, 32'd1);
    check("t1_addr", {16'd0, got_addr_q.size() > 0 ? got_addr_q[0] : 16'hFFFF}, 32'h5);
    check("t1_data", {16'd0, got_data_q.size() > 0 ? got_data_q[0] : 16'h0}, 32'h1234);

    // Backpressure: only BUF_DEPTH requests are admitted.
    clear_got();
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ADDR_W'(i), 1'b0, 1'b0, 1'b0, '0, '0);
      if (obs_ready) acc_cnt++;
    end
    check("t2_accepted", acc_cnt, 32'd4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("t2_full_ready", {31'd0, obs_ready}, 32'd0);
    idle(8);
    check("t2_count", got_data_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_data_q.size(); i++)
      check("t2_order", {16'd0, got_data_q[i]}, 32'hA0 + i);
    check("t2_ready_back", {31'd0, obs_ready}, 32'd1);

    // Address wrap.
    wr(16'd3, 16'hBEEF);
    clear_got();
    step(1'b1, 16'h0103, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);
    check("t3_count", got_data_q.size(), 32'd1);
    check("t3_addr", {16'd0, got_addr_q.size() > 0 ? got_addr_q[0] : 16'h0}, 32'h0103);
    check("t3_data", {16'd0, got_data_q.size() > 0 ? got_data_q[0] : 16'h0}, 32'hBEEF);

    // Flush with two in flight and one buffered.
    clear_got();
    step(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 16'd6, 1'b0, 1'b1, 1'b0, '0, '0);
    check("t4_flush_ready", {31'd0, obs_ready}, 32'd0);
    idle(5);
    check("t4_no_resp", got_data_q.size(), 32'd0);
    step(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);
    check("t4_after_cnt", got_data_q.size(), 32'd1);
    check("t4_after_data", {16'd0, got_data_q.size() > 0 ? got_data_q[0] : 16'h0}, 32'hA2);

    // Read-before-write on the same edge.
    wr(16'd9, 16'h1111);
    clear_got();
    step(1'b1, 16'd9, 1'b1, 1'b0, 1'b1, 16'd9, 16'h5555);
    idle(4);
    step(1'b1, 16'd9, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);
    check("t5_count", got_data_q.size(), 32'd2);
    check("t5_old", {16'd0, got_data_q.size() > 0 ? got_data_q[0] : 16'h0}, 32'h1111);
    check("t5_new", {16'd0, got_data_q.size() > 1 ? got_data_q[1] : 16'h0}, 32'h5555);

`ifdef IMEM_PARITY_EN
    // Flip one stored bit behind the write port's back.
    @(negedge clk);
    dut.mem_q[4] = dut.mem_q[4] ^ DATA_W'(1);
    mdl_mem[4]   = mdl_mem[4] ^ DATA_W'(1);
    mdl_bad[4]   = 1'b1;
    clear_got();
    step(1'b1, 16'd4, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 16'd5, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(5);
    check("t6_count", got_data_q.size(), 32'd2);
    check("t6_perr4", {31'd0, got_perr_q.size() > 0 ? got_perr_q[0] : 1'b0}, 32'd1);
    check("t6_data4", {16'd0, got_data_q.size() > 0 ? got_data_q[0] : 16'h0},
          {16'd0, mdl_mem[4]});
    check("t6_perr5", {31'd0, got_perr_q.size() > 1 ? got_perr_q[1] : 1'b1}, 32'd0);
`endif

    // Random traffic.
    for (int c = 0; c < 2000; c++)
      step($urandom_range(0, 9) < 7, ADDR_W'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, ADDR_W'($urandom),
           DATA_W'($urandom));

    // Reset mid-operation drops everything outstanding.
    for (int i = 0; i < 3; i++) step(1'b1, ADDR_W'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    do_reset();
    clear_got();
    idle(6);
    check("t7_no_resp", got_data_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
